mem_access_unit: RTL and testbench

Load/store front end for the MIPS data memory. It sits between the MEM pipeline stage and the word-organised data memory, which has a combinational read port and a word-wide synchronous write port. It turns byte, halfword and word requests into whole-word memory cycles:
- loads: byte/halfword extraction with zero or sign extension;
- sub-word stores: read-modify-write;
- misaligned or reserved-size requests: flagged, with no memory access.

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ==========================================================================
// mem_access_unit: byte/half/word load-store front end for word-wide memory
// Revision: 1.0
// ==========================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    sign_ext_q, sign_ext_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             merge_q, merge_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_bad;
  logic [31:0]             lane_shift;
  logic [15:0]             lane_half;
  logic [31:0]             load_val;
  logic [31:0]             merged;

  assign req_bad = (size == 2'b11) ||
                   ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    lane_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_val = {{16{sign_ext_q & lane_half[15]}}, lane_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Only the addressed lane is replaced; the rest keeps the word just read.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sign_ext_d = sign_ext;
          addr_d     = addr;
          wdata_d    = wdata;
          err_d      = req_bad;
          if (req_bad)            state_d = S_DONE;
          else if (!we)           state_d = S_LOAD;
          else if (size == 2'b10) state_d = S_WR;
          else                    state_d = S_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_DONE;
      end
      S_RD: begin
        merge_d = merged;
        state_d = S_WR;
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign err   = (state_q == S_DONE) && err_q;
  assign rdata = rdata_q;

  // clr gates the write strobe combinationally so an aborted WR never lands.
  assign mem_we    = (state_q == S_WR) && !clr;
  assign mem_addr  = ((state_q == S_LOAD) || (state_q == S_RD) || (state_q == S_WR)) ?
                     {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? ((size_q == 2'b10) ? wdata_q : merge_q) : 32'h0;

  // we_q is kept for completeness of the captured request.
  logic unused_we;
  assign unused_we = we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Self-checking bench for mem_access_unit: vector table plus reset/handshake sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr, req, we, sign_ext;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic [31:0] mem [0:1023];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        se;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          we_cyc;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int cyc, lat, we_cnt, we_at;
    logic got_err;
    logic [31:0] got_rdata, got_wdata;
    logic [11:0] addr1;
    v = vecs[i];
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.se; addr = v.addr; wdata = v.wdata;
    cyc = 0; lat = -1; we_cnt = 0; we_at = 0; got_err = 1'b0;
    got_rdata = 32'h0; got_wdata = 32'h0; addr1 = 12'h0;
    #1;
    while (cyc < 10) begin
      if (cyc == 1) addr1 = mem_addr;
      if (mem_we) begin we_cnt++; we_at = cyc; got_wdata = mem_wdata; end
      if (done) begin lat = cyc; got_err = err; got_rdata = rdata; break; end
      step();
      req = 1'b0;
      cyc++;
    end
    check($sformatf("v%0d latency", i), lat, v.lat);
    check($sformatf("v%0d err", i), {31'b0, got_err}, {31'b0, v.err});
    check($sformatf("v%0d rdata", i), got_rdata, v.rdata);
    check($sformatf("v%0d mem_we count", i), we_cnt, (v.we_cyc != 0) ? 1 : 0);
    if (v.we_cyc != 0) begin
      check($sformatf("v%0d mem_we cycle", i), we_at, v.we_cyc);
      check($sformatf("v%0d mem_wdata", i), got_wdata, v.word);
      check($sformatf("v%0d mem word", i), mem[v.addr[11:2]], v.word);
    end
    if (!v.err) check($sformatf("v%0d mem_addr c1", i), {20'b0, addr1}, {20'b0, v.addr[11:2], 2'b00});
    step();
  endtask

  initial begin
    int dones, accesses;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[4] = 32'h8899AABB;

    //         we    size   se    addr     wdata         lat err   rdata         wec word
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        2, 1'b0, 32'hFFFFFF88, 0, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        2, 1'b0, 32'h00000088, 0, 32'h0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        2, 1'b0, 32'hFFFF8899, 0, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        2, 1'b0, 32'h00008899, 0, 32'h0};
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 12'h010, 32'h0,        2, 1'b0, 32'h8899AABB, 0, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 12'h010, 32'h0,        2, 1'b0, 32'hFFFFFFBB, 0, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        2, 1'b0, 32'hFFFFAABB, 0, 32'h0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFFCC, 3, 1'b0, 32'hFFFFAABB, 2, 32'h8899CCBB};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        2, 1'b0, 32'h8899CCBB, 0, 32'h0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 12'h014, 32'h12345678, 2, 1'b0, 32'h8899CCBB, 1, 32'h12345678};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        2, 1'b0, 32'h12345678, 0, 32'h0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 12'h016, 32'hABCD5555, 3, 1'b0, 32'h12345678, 2, 32'h55555678};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        2, 1'b0, 32'h55555678, 0, 32'h0};
    vecs[13] = '{1'b0, 2'b01, 1'b1, 12'h011, 32'h0,        1, 1'b1, 32'h55555678, 0, 32'h0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 12'h012, 32'hDEADBEEF, 1, 1'b1, 32'h55555678, 0, 32'h0};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 12'h010, 32'h0,        1, 1'b1, 32'h55555678, 0, 32'h0};
    vecs[16] = '{1'b1, 2'b00, 1'b0, 12'h017, 32'h000000EE, 3, 1'b0, 32'h55555678, 2, 32'hEE555678};
    vecs[17] = '{1'b0, 2'b00, 1'b0, 12'h017, 32'h0,        2, 1'b0, 32'h000000EE, 0, 32'h0};
    vecs[18] = '{1'b1, 2'b00, 1'b0, 12'h011, 32'h123456AA, 3, 1'b0, 32'h000000EE, 2, 32'h8899AABB};

    clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 12'h0; wdata = 32'h0;
    step(); step();
    clr = 1'b0;
    #1;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_addr", {20'b0, mem_addr}, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    step();

    for (int i = 0; i < 19; i++) run_vec(i);

    // Abort a half store in its WR cycle: memory must stay untouched.
    req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 12'h010; wdata = 32'h00001234;
    step();
    req = 1'b0;
    #1;
    check("abort rd busy", {31'b0, busy}, 32'h1);
    step();
    clr = 1'b1;
    #1;
    check("abort wr mem_we", {31'b0, mem_we}, 32'h0);
    step();
    clr = 1'b0;
    #1;
    check("abort word kept", mem[4], 32'h8899AABB);
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort done", {31'b0, done}, 32'h0);
    check("abort rdata", rdata, 32'h0);
    check("abort mem_addr", {20'b0, mem_addr}, 32'h0);
    step();

    // clr and req together: the request is dropped.
    req = 1'b1; clr = 1'b1; we = 1'b0; size = 2'b10; addr = 12'h010;
    step();
    req = 1'b0; clr = 1'b0;
    #1;
    check("clr+req busy", {31'b0, busy}, 32'h0);
    step();

    // req held high: one access per IDLE acceptance (two in six cycles).
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 12'h010;
    dones = 0; accesses = 0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (done) dones++;
      if (mem_addr != 12'h0) accesses++;
      step();
    end
    req = 1'b0;
    #1;
    check("held req done pulses", dones, 2);
    check("held req accesses", accesses, 2);
    check("held req rdata", rdata, 32'h8899AABB);
    check("held req idle", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
